mem_copy_engine: RTL

Block-transfer initiator that drives the data memory's read/write port pair to copy a contiguous region (memmove semantics, overlap-safe) or fill a region with a constant. It moves one word per clock using the memory's asynchronous read and synchronous write. It sits beside the CPU core as a memory-port master, with its port muxed against the core's load/store path. It reports completion with a one-cycle `done` pulse.

---
 rtl/panda_mem_pkg.sv | 14 +
 rtl/mem_copy_engine.sv | 107 ++++++++++
 2 files changed

// File: rtl/panda_mem_pkg.sv
// Shared types for the memory block-transfer engine.
// State encoding and transfer-mode constants.
package panda_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory-port master that copies (memmove, overlap-safe) or fills a
// region one word per clock using async read and sync write.
module mem_copy_engine
    import panda_mem_pkg::*;
#(
    parameter int DATA_PATH_WIDTH = 8,
    parameter int ADDR_WIDTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic [ADDR_WIDTH-1:0]      src_addr,
    input  logic [ADDR_WIDTH-1:0]      dst_addr,
    input  logic [ADDR_WIDTH:0]        length,
    input  logic [DATA_PATH_WIDTH-1:0] fill_value,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_wen,
    output logic [ADDR_WIDTH-1:0]      mem_read_addr,
    output logic [ADDR_WIDTH-1:0]      mem_write_addr,
    output logic [DATA_PATH_WIDTH-1:0] mem_write_data,
    input  logic [DATA_PATH_WIDTH-1:0] mem_read_data
);

    state_t                     state;
    logic                       mode_q;
    logic                       bwd;
    logic [DATA_PATH_WIDTH-1:0] fill_q;
    logic [ADDR_WIDTH:0]        remaining;

    logic [ADDR_WIDTH-1:0]      diff;
    logic [ADDR_WIDTH-1:0]      len_m1;
    logic                       overlap;
    logic [ADDR_WIDTH-1:0]      step;

    // Backward only when the destination starts inside the live source range.
    assign diff    = dst_addr - src_addr;
    assign len_m1  = length[ADDR_WIDTH-1:0] - 1'b1;
    assign overlap = (mode == MODE_COPY)
                   && (diff != '0)
                   && ({1'b0, diff} < length);
    assign step    = bwd ? '1 : ADDR_WIDTH'(1);

    assign mem_write_data = (mode_q == MODE_FILL) ? fill_q : mem_read_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_wen        <= 1'b0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            remaining      <= '0;
            mode_q         <= MODE_COPY;
            fill_q         <= '0;
            bwd            <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mode_q    <= mode;
                        fill_q    <= fill_value;
                        remaining <= length;
                        bwd       <= overlap;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= XFER;
                            busy    <= 1'b1;
                            mem_wen <= 1'b1;
                            if (overlap) begin
                                mem_read_addr  <= src_addr + len_m1;
                                mem_write_addr <= dst_addr + len_m1;
                            end else begin
                                mem_read_addr  <= src_addr;
                                mem_write_addr <= dst_addr;
                            end
                        end
                    end
                end
                XFER: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_WIDTH+1)'(1)) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        mem_wen <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        mem_read_addr  <= mem_read_addr + step;
                        mem_write_addr <= mem_write_addr + step;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
